// File: rtl/hazard_ctrl_mc_if.sv
// Purpose : hazard-controller bundle between the RV32 pipeline (master) and hazard_ctrl_mc (slave).
// Latency : pure wiring, no storage.
// Backpr. : none; the slave drives pc_write/if_id_write/pipe_freeze, which act as the pipeline's stall controls.
// Ports   : master drives hazard sources (branch, mem_busy, EXE/ID register fields, MDU start)
//           and receives pipeline controls plus MDU status; slave is the mirror image.
//           HAZARD_PERF_EN adds stall_cnt/flush_cnt (32-bit) driven by the slave.
interface hazard_ctrl_mc_if #(
    parameter int REG_ADDR_W = 5
);
    logic [1:0]            branch_sel;
    logic                  mem_busy;
    logic                  exe_mem_read;
    logic [REG_ADDR_W-1:0] exe_rd_addr;
    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic                  id_mdu_start;
    logic [REG_ADDR_W-1:0] id_rd_addr;
    logic                  pc_write;
    logic                  if_id_write;
    logic                  if_id_flush;
    logic                  id_exe_flush;
    logic                  pipe_freeze;
    logic                  mdu_issue;
    logic                  mdu_busy;
    logic                  mdu_done;
    logic [REG_ADDR_W-1:0] mdu_rd_addr;
`ifdef HAZARD_PERF_EN
    logic [31:0]           stall_cnt;
    logic [31:0]           flush_cnt;

    modport master (
        output branch_sel, mem_busy, exe_mem_read, exe_rd_addr, id_rs1_addr, id_rs2_addr,
               id_rs1_used, id_rs2_used, id_mdu_start, id_rd_addr,
        input  pc_write, if_id_write, if_id_flush, id_exe_flush, pipe_freeze,
               mdu_issue, mdu_busy, mdu_done, mdu_rd_addr, stall_cnt, flush_cnt
    );
    modport slave (
        input  branch_sel, mem_busy, exe_mem_read, exe_rd_addr, id_rs1_addr, id_rs2_addr,
               id_rs1_used, id_rs2_used, id_mdu_start, id_rd_addr,
        output pc_write, if_id_write, if_id_flush, id_exe_flush, pipe_freeze,
               mdu_issue, mdu_busy, mdu_done, mdu_rd_addr, stall_cnt, flush_cnt
    );
`else
    modport master (
        output branch_sel, mem_busy, exe_mem_read, exe_rd_addr, id_rs1_addr, id_rs2_addr,
               id_rs1_used, id_rs2_used, id_mdu_start, id_rd_addr,
        input  pc_write, if_id_write, if_id_flush, id_exe_flush, pipe_freeze,
               mdu_issue, mdu_busy, mdu_done, mdu_rd_addr
    );
    modport slave (
        input  branch_sel, mem_busy, exe_mem_read, exe_rd_addr, id_rs1_addr, id_rs2_addr,
               id_rs1_used, id_rs2_used, id_mdu_start, id_rd_addr,
        output pc_write, if_id_write, if_id_flush, id_exe_flush, pipe_freeze,
               mdu_issue, mdu_busy, mdu_done, mdu_rd_addr
    );
`endif
endinterface

// File: rtl/hazard_ctrl_mc.sv
// Purpose : multi-cycle hazard control beside ID: load-use stall FSM, MDU scoreboard, mem freeze, branch flush.
// Latency : all pipeline controls are combinational from current inputs and state; MDU done pulses MDU_LAT-1 cycles after the issue edge.
// Backpr. : mem_busy freezes everything except the MDU counter; stalls hold PC and IF/ID and inject an ID/EXE bubble.
// Ports   : clk, rst_n (async active-low); hz = hazard_ctrl_mc_if.slave bundle.
// Config  : define HAZARD_PERF_EN to add 32-bit stall_cnt/flush_cnt performance counters.
module hazard_ctrl_mc #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_STALL = 1,
    parameter int MDU_LAT    = 4,
    parameter int CNT_W      = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    hazard_ctrl_mc_if.slave hz
);
    typedef enum logic {RUN = 1'b0, LU_STALL = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0]      mdu_cnt_q;
    logic                  mdu_busy_q;
    logic [REG_ADDR_W-1:0] mdu_rd_q;

    logic lu_hit, mdu_hit;
    logic sel_freeze, sel_flush, sel_stall, sel_run;
    logic issue;

    // x0 is never a real dependency, and an unused source field is don't-care.
    function automatic logic src_match(input logic [REG_ADDR_W-1:0] rx,
                                       input logic [REG_ADDR_W-1:0] rs1, input logic u1,
                                       input logic [REG_ADDR_W-1:0] rs2, input logic u2);
        return (rx != '0) && ((u1 && (rs1 == rx)) || (u2 && (rs2 == rx)));
    endfunction

    assign lu_hit  = hz.exe_mem_read &&
                     src_match(hz.exe_rd_addr, hz.id_rs1_addr, hz.id_rs1_used,
                               hz.id_rs2_addr, hz.id_rs2_used);
    // A second MDU op while one is outstanding is a structural hazard.
    assign mdu_hit = mdu_busy_q &&
                     (src_match(mdu_rd_q, hz.id_rs1_addr, hz.id_rs1_used,
                                hz.id_rs2_addr, hz.id_rs2_used) || hz.id_mdu_start);

    // Mutually exclusive per-cycle actions in priority order.
    assign sel_freeze = hz.mem_busy;
    assign sel_flush  = !sel_freeze && (hz.branch_sel != 2'b00);
    assign sel_stall  = !sel_freeze && !sel_flush && ((state_q == LU_STALL) || lu_hit || mdu_hit);
    assign sel_run    = !sel_freeze && !sel_flush && !sel_stall;
    assign issue      = sel_run && hz.id_mdu_start;

    // Load-use FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            lu_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            lu_cnt_q <= lu_cnt_d;
        end
    end

    // Load-use FSM: next state. The detection cycle is the first bubble, so
    // LU_STALL covers the remaining LOAD_STALL-1 cycles.
    always_comb begin
        state_d  = state_q;
        lu_cnt_d = lu_cnt_q;
        if (sel_flush) begin
            state_d  = RUN;
            lu_cnt_d = '0;
        end else if (!sel_freeze) begin
            if (state_q == RUN) begin
                if (lu_hit && (LOAD_STALL > 1)) begin
                    state_d  = LU_STALL;
                    lu_cnt_d = CNT_W'(LOAD_STALL - 1);
                end
            end else begin
                if (lu_cnt_q <= CNT_W'(1)) begin
                    state_d  = RUN;
                    lu_cnt_d = '0;
                end else begin
                    lu_cnt_d = lu_cnt_q - CNT_W'(1);
                end
            end
        end
    end

    // Load-use FSM / pipeline controls: outputs
    always_comb begin
        hz.pc_write     = 1'b1;
        hz.if_id_write  = 1'b1;
        hz.if_id_flush  = 1'b0;
        hz.id_exe_flush = 1'b0;
        hz.pipe_freeze  = 1'b0;
        if (sel_freeze) begin
            hz.pipe_freeze = 1'b1;
            hz.pc_write    = 1'b0;
            hz.if_id_write = 1'b0;
        end else if (sel_flush) begin
            hz.if_id_flush  = 1'b1;
            hz.id_exe_flush = 1'b1;
        end else if (sel_stall) begin
            hz.pc_write     = 1'b0;
            hz.if_id_write  = 1'b0;
            hz.id_exe_flush = 1'b1;
        end
        hz.mdu_issue   = issue;
        hz.mdu_busy    = mdu_busy_q;
        hz.mdu_done    = mdu_busy_q && (mdu_cnt_q == CNT_W'(1));
        hz.mdu_rd_addr = mdu_rd_q;
    end

    // MDU scoreboard: runs through freezes and flushes, since the op in flight
    // is older than anything being squashed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdu_busy_q <= 1'b0;
            mdu_cnt_q  <= '0;
            mdu_rd_q   <= '0;
        end else if (issue) begin
            mdu_busy_q <= 1'b1;
            mdu_cnt_q  <= CNT_W'(MDU_LAT);
            mdu_rd_q   <= hz.id_rd_addr;
        end else if (mdu_busy_q) begin
            mdu_cnt_q <= mdu_cnt_q - CNT_W'(1);
            if (mdu_cnt_q == CNT_W'(1)) begin
                mdu_busy_q <= 1'b0;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (sel_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (sel_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Purpose : directed scoreboard bench for hazard_ctrl_mc with LOAD_STALL=2, MDU_LAT=4.
// Latency : one stimulus vector per clock; expected outputs checked at the following falling edge.
// Backpr. : none; the bench follows a fixed cycle schedule.
module tb_hazard_ctrl_mc;
    localparam int W = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_mc_if #(.REG_ADDR_W(W)) hz ();

    hazard_ctrl_mc #(
        .REG_ADDR_W(W),
        .LOAD_STALL(2),
        .MDU_LAT   (4),
        .CNT_W     (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (hz)
    );

    // Expected word: {pc_write, if_id_write, if_id_flush, id_exe_flush,
    //                 pipe_freeze, mdu_issue, mdu_busy, mdu_done, mdu_rd_addr}
    typedef struct {
        logic [12:0] exp;
        string       nm;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Monitor: compares whenever an expectation is pending for this cycle.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [12:0] got;
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            got = {hz.pc_write, hz.if_id_write, hz.if_id_flush, hz.id_exe_flush,
                   hz.pipe_freeze, hz.mdu_issue, hz.mdu_busy, hz.mdu_done, hz.mdu_rd_addr};
            n_chk++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %b_%b required %b_%b",
                         e.nm, got[12:5], got[4:0], e.exp[12:5], e.exp[4:0]);
            end
        end
    end

    task automatic cyc(input logic r, input logic [1:0] br, input logic mb,
                       input logic lr, input logic [W-1:0] erd,
                       input logic [W-1:0] rs1, input logic u1,
                       input logic [W-1:0] rs2, input logic u2,
                       input logic ms, input logic [W-1:0] idrd,
                       input logic [7:0] ef, input logic [W-1:0] rd, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n           = r;
        hz.branch_sel   = br;
        hz.mem_busy     = mb;
        hz.exe_mem_read = lr;
        hz.exe_rd_addr  = erd;
        hz.id_rs1_addr  = rs1;
        hz.id_rs1_used  = u1;
        hz.id_rs2_addr  = rs2;
        hz.id_rs2_used  = u2;
        hz.id_mdu_start = ms;
        hz.id_rd_addr   = idrd;
        e.exp = {ef, rd};
        e.nm  = nm;
        sb_q.push_back(e);
    endtask

    initial begin
        hz.branch_sel   = 2'b00;
        hz.mem_busy     = 1'b0;
        hz.exe_mem_read = 1'b0;
        hz.exe_rd_addr  = '0;
        hz.id_rs1_addr  = '0;
        hz.id_rs1_used  = 1'b0;
        hz.id_rs2_addr  = '0;
        hz.id_rs2_used  = 1'b0;
        hz.id_mdu_start = 1'b0;
        hz.id_rd_addr   = '0;

        //  r  br    mb lr erd  rs1 u1 rs2 u2 ms rd   flags          mdu_rd name
        cyc(0, 2'd0, 0, 0, 0,   0, 0, 0, 0,  0, 0,  8'b1100_0000, 0, "reset");
        cyc(1, 2'd0, 0, 0, 0,   0, 0, 0, 0,  0, 0,  8'b1100_0000, 0, "idle");
        // load-use on rs1, two bubbles
        cyc(1, 2'd0, 0, 1, 5,   5, 1, 0, 0,  0, 0,  8'b0001_0000, 0, "lu_detect");
        cyc(1, 2'd0, 0, 0, 0,   5, 1, 0, 0,  0, 0,  8'b0001_0000, 0, "lu_stall2");
        cyc(1, 2'd0, 0, 0, 0,   5, 1, 0, 0,  0, 0,  8'b1100_0000, 0, "lu_release");
        cyc(1, 2'd0, 0, 1, 0,   0, 1, 0, 0,  0, 0,  8'b1100_0000, 0, "x0_load");
        // load-use on rs2, branch in the second stall cycle
        cyc(1, 2'd0, 0, 1, 9,   0, 0, 9, 1,  0, 0,  8'b0001_0000, 0, "lu_rs2");
        cyc(1, 2'd1, 0, 0, 0,   0, 0, 0, 0,  0, 0,  8'b1111_0000, 0, "br_in_stall");
        cyc(1, 2'd0, 0, 0, 0,   0, 0, 0, 0,  0, 0,  8'b1100_0000, 0, "br_run");
        cyc(1, 2'd0, 0, 1, 5,   5, 0, 0, 0,  0, 0,  8'b1100_0000, 0, "unused_src");
        // mem_busy for 3 cycles inside a load-use stall
        cyc(1, 2'd0, 0, 1, 6,   6, 1, 0, 0,  0, 0,  8'b0001_0000, 0, "lu2_detect");
        cyc(1, 2'd0, 1, 0, 0,   6, 1, 0, 0,  0, 0,  8'b0000_1000, 0, "freeze1");
        cyc(1, 2'd0, 1, 0, 0,   6, 1, 0, 0,  0, 0,  8'b0000_1000, 0, "freeze2");
        cyc(1, 2'd0, 1, 0, 0,   6, 1, 0, 0,  0, 0,  8'b0000_1000, 0, "freeze3");
        cyc(1, 2'd0, 0, 0, 0,   6, 1, 0, 0,  0, 0,  8'b0001_0000, 0, "lu2_extend");
        cyc(1, 2'd0, 0, 0, 0,   6, 1, 0, 0,  0, 0,  8'b1100_0000, 0, "lu2_release");
        // MDU dependency on x7
        cyc(1, 2'd0, 0, 0, 0,   0, 0, 0, 0,  1, 7,  8'b1100_0100, 0, "mdu_issue");
        cyc(1, 2'd0, 0, 0, 0,   7, 1, 0, 0,  0, 0,  8'b0001_0010, 7, "mdu_wait1");
        cyc(1, 2'd0, 0, 0, 0,   7, 1, 0, 0,  0, 0,  8'b0001_0010, 7, "mdu_wait2");
        cyc(1, 2'd0, 0, 0, 0,   7, 1, 0, 0,  0, 0,  8'b0001_0010, 7, "mdu_wait3");
        cyc(1, 2'd0, 0, 0, 0,   7, 1, 0, 0,  0, 0,  8'b0001_0011, 7, "mdu_done");
        cyc(1, 2'd0, 0, 0, 0,   7, 1, 0, 0,  0, 0,  8'b1100_0000, 7, "mdu_release");
        // back-to-back MDU ops, freeze while counting
        cyc(1, 2'd0, 0, 0, 0,   0, 0, 0, 0,  1, 8,  8'b1100_0100, 7, "b2b_issue1");
        cyc(1, 2'd0, 0, 0, 0,   0, 0, 0, 0,  1, 9,  8'b0001_0010, 8, "b2b_struct");
        cyc(1, 2'd0, 1, 0, 0,   0, 0, 0, 0,  1, 9,  8'b0000_1010, 8, "mdu_freeze");
        cyc(1, 2'd0, 0, 0, 0,   0, 0, 0, 0,  1, 9,  8'b0001_0010, 8, "b2b_wait");
        cyc(1, 2'd0, 0, 0, 0,   0, 0, 0, 0,  1, 9,  8'b0001_0011, 8, "b2b_done");
        cyc(1, 2'd0, 0, 0, 0,   0, 0, 0, 0,  1, 9,  8'b1100_0100, 8, "b2b_issue2");
        cyc(1, 2'd0, 0, 0, 0,   0, 0, 0, 0,  0, 0,  8'b1100_0010, 9, "mdu_busy");
        // branch squashes an ID MDU op but not the one in flight
        cyc(1, 2'd2, 0, 0, 0,   0, 0, 0, 0,  1, 3,  8'b1111_0010, 9, "br_keeps_mdu");
        cyc(1, 2'd0, 0, 0, 0,   0, 0, 0, 0,  0, 0,  8'b1100_0010, 9, "mdu_keep");
        // async reset in what would be the done cycle
        cyc(0, 2'd0, 0, 0, 0,   0, 0, 0, 0,  0, 0,  8'b1100_0000, 0, "rst_mid_mdu");
        cyc(1, 2'd0, 0, 0, 0,   0, 0, 0, 0,  0, 0,  8'b1100_0000, 0, "post_reset");
        // branch outranks a simultaneous load-use and must not enter LU_STALL
        cyc(1, 2'd1, 0, 1, 3,   3, 1, 0, 0,  0, 0,  8'b1111_0000, 0, "br_over_lu");
        cyc(1, 2'd0, 0, 0, 0,   0, 0, 0, 0,  0, 0,  8'b1100_0000, 0, "br_over_lu_run");

        repeat (2) @(posedge clk);
        n_chk++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
